// File: rtl/int_ctrl.sv
// int_ctrl: six-source interrupt controller with pend/mask/mode/current registers
// and an IDLE -> REQ -> SERVICE handshake towards the CPU.
// Optional feature macro INT_CTRL_EDGE_EN: per-source edge mode (MODE register,
// rising-edge latching with PEND write-1-to-clear). Without it every source is level.
module int_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  irq_in,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   input  logic        int_ack,
   output logic        int_req,
   output logic [2:0]  int_code
);

   localparam int unsigned N_SRC  = 6;
   localparam int unsigned ID_W   = 3;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [N_SRC-1:0]  pend_q, pend_d;
   logic [N_SRC-1:0]  mask_q, mask_d;
   logic [N_SRC-1:0]  mode_rd_c;
   logic [N_SRC-1:0]  active_c;
   logic              cur_valid_q, cur_valid_d;
   logic [ID_W-1:0]   cur_id_q, cur_id_d;
   logic              int_req_q, int_req_d;
   logic [ID_W-1:0]   code_c;
   logic              wr_mask_c;
   logic              eoi_c;
   logic              take_ack_c;
   logic              unused_din_c;

   assign wr_mask_c    = WE && (Addr == 2'd1);
   assign eoi_c        = WE && (Addr == 2'd3);
   assign active_c     = pend_q & mask_q;
   assign take_ack_c   = (state_q == REQ) && (active_c != '0) && int_ack;
   assign unused_din_c = ^Din[DATA_W-1:N_SRC];

   // Lowest-index pending and enabled source wins; zero when nothing is active
   always_comb begin
      code_c = '0;
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
         if (active_c[i]) code_c = ID_W'(i);
      end
   end

`ifdef INT_CTRL_EDGE_EN
   logic [N_SRC-1:0] irq_q;
   logic [N_SRC-1:0] mode_q, mode_d;
   logic [N_SRC-1:0] rise_c, clr_c, ack_clr_c;
   logic             wr_pend_c, wr_mode_c;

   assign wr_pend_c = WE && (Addr == 2'd0);
   assign wr_mode_c = WE && (Addr == 2'd2);

   // Edge bits: a new rising edge beats any clear; ack clear and W1C both only clear
   always_comb begin
      rise_c    = irq_in & ~irq_q;
      ack_clr_c = take_ack_c ? (N_SRC'(1) << code_c) : '0;
      clr_c     = (wr_pend_c ? Din[N_SRC-1:0] : '0) | ack_clr_c;
      pend_d    = (mode_q & (rise_c | (pend_q & ~clr_c))) | (~mode_q & irq_in);
      mode_d    = wr_mode_c ? Din[N_SRC-1:0] : mode_q;
      mode_rd_c = mode_q;
   end

   // Previous-cycle source sample and mode register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_q  <= '0;
         mode_q <= '0;
      end else begin
         irq_q  <= irq_in;
         mode_q <= mode_d;
      end
   end
`else
   // Level-only build: pending simply follows the sampled sources
   always_comb begin
      pend_d    = irq_in;
      mode_rd_c = '0;
   end
`endif

   // Mask register update
   always_comb begin
      mask_d = mask_q;
      if (wr_mask_c) mask_d = Din[N_SRC-1:0];
   end

   // Request handshake: next state, in-service capture and request flag
   always_comb begin
      state_d     = state_q;
      cur_valid_d = cur_valid_q;
      cur_id_d    = cur_id_q;
      case (state_q)
         IDLE: begin
            if (active_c != '0) state_d = REQ;
         end
         REQ: begin
            if (active_c == '0) begin
               state_d = IDLE;
            end else if (take_ack_c) begin
               state_d     = SERVICE;
               cur_valid_d = 1'b1;
               cur_id_d    = code_c;
            end
         end
         SERVICE: begin
            if (eoi_c) begin
               state_d     = IDLE;
               cur_valid_d = 1'b0;
               cur_id_d    = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      int_req_d = (state_d == REQ);
   end

   // State and register bank
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         mask_q      <= '0;
         cur_valid_q <= 1'b0;
         cur_id_q    <= '0;
         int_req_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         mask_q      <= mask_d;
         cur_valid_q <= cur_valid_d;
         cur_id_q    <= cur_id_d;
         int_req_q   <= int_req_d;
      end
   end

   // Read mux of the pre-edge register contents
   always_comb begin
      Dout = '0;
      case (Addr)
         2'd0:    Dout[N_SRC-1:0] = pend_q;
         2'd1:    Dout[N_SRC-1:0] = mask_q;
         2'd2:    Dout[N_SRC-1:0] = mode_rd_c;
         2'd3:    Dout[ID_W:0]    = {cur_valid_q, cur_id_q};
         default: Dout = '0;
      endcase
   end

   assign int_req  = int_req_q;
   assign int_code = code_c;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: scoreboard bench for int_ctrl; a cycle model pushes expected outputs
// when each cycle's stimulus is driven, a negedge checker pops and compares them.
module tb_int_ctrl;

`ifdef INT_CTRL_EDGE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [5:0]  irq_in;
   logic [1:0]  Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        int_ack;
   logic        int_req;
   logic [2:0]  int_code;

   int_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .irq_in   (irq_in),
      .Addr     (Addr),
      .WE       (WE),
      .Din      (Din),
      .Dout     (Dout),
      .int_ack  (int_ack),
      .int_req  (int_req),
      .int_code (int_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        req;
      logic [2:0]  code;
      logic [31:0] dout;
   } exp_t;

   exp_t exp_q[$];
   exp_t sb_e;
   int   checks   = 0;
   int   failures = 0;

   // reference model state (0 idle, 1 request, 2 service)
   logic [5:0] m_pend, m_mask, m_mode, m_irq;
   int         m_st;
   logic       m_cv;
   logic [2:0] m_cid;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] lowest_set(input logic [5:0] v);
      for (int i = 0; i < 6; i++) begin
         if (v[i]) return 3'(i);
      end
      return 3'd0;
   endfunction

   function automatic exp_t model_out(input logic [1:0] a);
      exp_t e;
      e.req  = (m_st == 1);
      e.code = lowest_set(m_pend & m_mask);
      case (a)
         2'd0:    e.dout = {26'd0, m_pend};
         2'd1:    e.dout = {26'd0, m_mask};
         2'd2:    e.dout = EDGE ? {26'd0, m_mode} : 32'd0;
         default: e.dout = {28'd0, m_cv, m_cid};
      endcase
      return e;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_mask = '0; m_mode = '0; m_irq = '0;
      m_st = 0; m_cv = 1'b0; m_cid = '0;
   endtask

   task automatic model_step(input logic [5:0] irq, input logic we, input logic [1:0] a,
                             input logic [31:0] d, input logic ack);
      logic [5:0] act, np;
      logic [2:0] w;
      logic       take;
      if (!reset) begin
         model_reset();
         return;
      end
      act  = m_pend & m_mask;
      w    = lowest_set(act);
      take = (m_st == 1) && (act != 0) && ack;
      for (int i = 0; i < 6; i++) begin
         if (EDGE && m_mode[i]) begin
            if (irq[i] && !m_irq[i])                                np[i] = 1'b1;
            else if ((we && a == 2'd0 && d[i]) || (take && w == i)) np[i] = 1'b0;
            else                                                     np[i] = m_pend[i];
         end else begin
            np[i] = irq[i];
         end
      end
      case (m_st)
         0: if (act != 0) m_st = 1;
         1: begin
            if (act == 0) m_st = 0;
            else if (ack) begin m_st = 2; m_cv = 1'b1; m_cid = w; end
         end
         default: if (we && a == 2'd3) begin m_st = 0; m_cv = 1'b0; m_cid = '0; end
      endcase
      if (we && a == 2'd1) m_mask = d[5:0];
      if (EDGE && we && a == 2'd2) m_mode = d[5:0];
      m_pend = np;
      m_irq  = EDGE ? irq : 6'd0;
   endtask

   // one clock cycle of stimulus; expected outputs for this cycle go to the scoreboard
   task automatic cyc(input logic [5:0] irq, input logic we, input logic [1:0] a,
                      input logic [31:0] d, input logic ack);
      irq_in = irq; WE = we; Addr = a; Din = d; int_ack = ack;
      exp_q.push_back(model_out(a));
      @(posedge clk);
      model_step(irq, we, a, d, ack);
      #1;
   endtask

   // directed look at the post-edge outputs against fixed scenario values
   task automatic peek(input string tag, input logic [1:0] a, input logic [31:0] exp_dout,
                       input logic exp_req, input logic [2:0] exp_code);
      WE = 1'b0; int_ack = 1'b0; Addr = a;
      #1;
      check_val({tag, "_dout"}, Dout, exp_dout);
      check_val({tag, "_req"}, 32'(int_req), 32'(exp_req));
      check_val({tag, "_code"}, 32'(int_code), 32'(exp_code));
   endtask

   task automatic reset_pulse();
      reset = 1'b0;
      model_reset();
      cyc(6'h00, 1'b0, 2'd0, 32'd0, 1'b0);
      cyc(6'h00, 1'b0, 2'd0, 32'd0, 1'b0);
      reset = 1'b1;
   endtask

   // scoreboard checker, sampling on the inactive edge
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         sb_e = exp_q.pop_front();
         check_val("sb_req", 32'(int_req), 32'(sb_e.req));
         check_val("sb_code", 32'(int_code), 32'(sb_e.code));
         check_val("sb_dout", Dout, sb_e.dout);
      end
   end

   initial begin
      logic [5:0] r_irq;
      reset = 1'b0; irq_in = '0; Addr = '0; WE = 1'b0; Din = '0; int_ack = 1'b0;
      model_reset();
      @(posedge clk); #1;
      // reset values of every register, writes ignored while in reset
      for (int a = 0; a < 4; a++) cyc(6'h3f, 1'b1, 2'(a), 32'hffff_ffff, 1'b1);
      peek("rst_pend", 2'd0, 32'd0, 1'b0, 3'd0);
      peek("rst_cur", 2'd3, 32'd0, 1'b0, 3'd0);
      reset = 1'b1;

      // single level source: request, ack, EOI, re-request
      cyc(6'h00, 1'b1, 2'd1, 32'h1, 1'b0);
      cyc(6'h01, 1'b0, 2'd0, 32'd0, 1'b0);
      peek("l_pend", 2'd0, 32'h1, 1'b0, 3'd0);
      cyc(6'h01, 1'b0, 2'd0, 32'd0, 1'b0);
      peek("l_req", 2'd3, 32'h0, 1'b1, 3'd0);
      cyc(6'h01, 1'b0, 2'd3, 32'd0, 1'b1);
      peek("l_ack", 2'd3, 32'h8, 1'b0, 3'd0);
      cyc(6'h01, 1'b1, 2'd3, 32'd0, 1'b0);
      peek("l_eoi", 2'd3, 32'h0, 1'b0, 3'd0);
      cyc(6'h01, 1'b0, 2'd0, 32'd0, 1'b0);
      peek("l_rereq", 2'd0, 32'h1, 1'b1, 3'd0);

      // mask removal while requesting, then a stray ack
      cyc(6'h01, 1'b1, 2'd1, 32'h0, 1'b0);
      peek("m_wr", 2'd1, 32'h0, 1'b1, 3'd0);
      cyc(6'h01, 1'b0, 2'd0, 32'd0, 1'b0);
      peek("m_idle", 2'd0, 32'h1, 1'b0, 3'd0);
      cyc(6'h01, 1'b0, 2'd3, 32'd0, 1'b1);
      peek("m_stray", 2'd3, 32'h0, 1'b0, 3'd0);

      // two sources at once, bit1 edge-mode when available
      reset_pulse();
      cyc(6'h00, 1'b1, 2'd2, 32'h2, 1'b0);
      cyc(6'h00, 1'b1, 2'd1, 32'h7, 1'b0);
      cyc(6'h06, 1'b0, 2'd0, 32'd0, 1'b0);
      peek("p_pend", 2'd0, 32'h6, 1'b0, 3'd1);
      cyc(6'h06, 1'b0, 2'd0, 32'd0, 1'b0);
      peek("p_req", 2'd2, EDGE ? 32'h2 : 32'h0, 1'b1, 3'd1);
      cyc(6'h06, 1'b0, 2'd3, 32'd0, 1'b1);
      peek("p_ack", 2'd3, 32'h9, 1'b0, EDGE ? 3'd2 : 3'd1);
      cyc(6'h06, 1'b1, 2'd3, 32'd0, 1'b0);
      peek("p_eoi", 2'd3, 32'h0, 1'b0, EDGE ? 3'd2 : 3'd1);
      cyc(6'h06, 1'b0, 2'd0, 32'd0, 1'b0);
      peek("p_next", 2'd0, EDGE ? 32'h4 : 32'h6, 1'b1, EDGE ? 3'd2 : 3'd1);

      // new source while in service only pends until EOI
      reset_pulse();
      cyc(6'h00, 1'b1, 2'd2, 32'h2, 1'b0);
      cyc(6'h00, 1'b1, 2'd1, 32'h3, 1'b0);
      cyc(6'h01, 1'b0, 2'd0, 32'd0, 1'b0);
      cyc(6'h01, 1'b0, 2'd0, 32'd0, 1'b0);
      cyc(6'h01, 1'b0, 2'd0, 32'd0, 1'b1);
      peek("s_ack", 2'd3, 32'h8, 1'b0, 3'd0);
      cyc(6'h02, 1'b0, 2'd0, 32'd0, 1'b0);
      peek("s_pend", 2'd0, 32'h2, 1'b0, 3'd1);
      cyc(6'h02, 1'b0, 2'd0, 32'd0, 1'b1);
      cyc(6'h02, 1'b0, 2'd0, 32'd0, 1'b0);
      peek("s_hold", 2'd3, 32'h8, 1'b0, 3'd1);
      cyc(6'h02, 1'b1, 2'd3, 32'd0, 1'b0);
      peek("s_eoi", 2'd3, 32'h0, 1'b0, 3'd1);
      cyc(6'h02, 1'b0, 2'd0, 32'd0, 1'b0);
      peek("s_req", 2'd0, 32'h2, 1'b1, 3'd1);

      // one-cycle pulse on an edge source, then write-1-to-clear
      reset_pulse();
      cyc(6'h00, 1'b1, 2'd2, 32'h4, 1'b0);
      cyc(6'h00, 1'b1, 2'd1, 32'h4, 1'b0);
      cyc(6'h04, 1'b0, 2'd0, 32'd0, 1'b0);
      cyc(6'h00, 1'b0, 2'd0, 32'd0, 1'b0);
      peek("e_latch", 2'd0, EDGE ? 32'h4 : 32'h0, 1'b1, EDGE ? 3'd2 : 3'd0);
      cyc(6'h00, 1'b1, 2'd0, 32'h4, 1'b0);
      peek("e_w1c", 2'd0, 32'h0, EDGE, 3'd0);
      cyc(6'h00, 1'b0, 2'd0, 32'd0, 1'b0);
      peek("e_fall", 2'd0, 32'h0, 1'b0, 3'd0);

      // asynchronous reset during a request, source held through release
      reset_pulse();
      cyc(6'h00, 1'b1, 2'd1, 32'h1, 1'b0);
      cyc(6'h01, 1'b0, 2'd0, 32'd0, 1'b0);
      cyc(6'h01, 1'b0, 2'd0, 32'd0, 1'b0);
      peek("r_req", 2'd0, 32'h1, 1'b1, 3'd0);
      reset = 1'b0;
      model_reset();
      #1;
      check_val("r_async_req", 32'(int_req), 32'd0);
      check_val("r_async_pend", Dout, 32'd0);
      cyc(6'h01, 1'b0, 2'd0, 32'd0, 1'b0);
      cyc(6'h01, 1'b0, 2'd0, 32'd0, 1'b0);
      reset = 1'b1;
      cyc(6'h01, 1'b0, 2'd0, 32'd0, 1'b0);
      peek("r_first", 2'd0, 32'h1, 1'b0, 3'd0);

      // random traffic checked purely against the model
      reset_pulse();
      r_irq = '0;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 2) == 0) r_irq = 6'($urandom_range(0, 63));
         cyc(r_irq, ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
             $urandom, ($urandom_range(0, 3) == 0));
      end

      @(negedge clk); #1;
      check_val("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
